// File: rtl/mem_xbar_pkg.sv
// mem_xbar_pkg: shared types and the address decoder for the mem_xbar crossbar.
//   IDX_W    - width of a slave index (covers up to MAX_SLAVES slaves)
//   rsp_t    - per-master response record {valid, idx, err}
//   dec_t    - decode result {hit, idx}
//   decode() - table-driven decoder, lowest matching slave index wins
package mem_xbar_pkg;

    localparam int MAX_SLAVES = 16;
    localparam int ADDR_MAX   = 64;
    localparam int IDX_W      = $clog2(MAX_SLAVES);

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic valid;
        idx_t idx;
        logic err;
    } rsp_t;

    typedef struct packed {
        logic hit;
        idx_t idx;
    } dec_t;

    // Tables are zero-extended to ADDR_MAX bits per entry and MAX_SLAVES entries.
    function automatic dec_t decode(
        input logic [ADDR_MAX-1:0]            addr,
        input logic [MAX_SLAVES*ADDR_MAX-1:0] base,
        input logic [MAX_SLAVES*ADDR_MAX-1:0] mask,
        input int                             n_slaves
    );
        dec_t res;
        res = '0;
        // Scan from the top so the lowest matching index is the last one written.
        for (int j = MAX_SLAVES - 1; j >= 0; j--) begin
            if ((j < n_slaves) &&
                ((addr & mask[j*ADDR_MAX +: ADDR_MAX]) == base[j*ADDR_MAX +: ADDR_MAX])) begin
                res.hit = 1'b1;
                res.idx = idx_t'(j);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_xbar_if.sv
// mem_xbar_if: bundle of all master-side and slave-side bus signals of mem_xbar.
//   m_req_i/m_gnt_o/m_rvalid_o/m_err_o - per-master handshake
//   m_addr_i/m_we_i/m_be_i/m_wdata_i   - per-master request payload
//   m_rdata_o                          - per-master read data (qualified by rvalid)
//   s_en_o/s_addr_o/s_we_o/s_be_o/s_wdata_o - per-slave access
//   s_rdata_i                          - per-slave read data, one cycle after s_en_o
// Modports: xbar (the crossbar), master (requesters), slave (memories).
interface mem_xbar_if #(
    parameter int NUM_MASTERS      = 2,
    parameter int NUM_SLAVES       = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int SLAVE_ADDR_WIDTH = 13
);
    import mem_xbar_pkg::*;

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [NUM_MASTERS-1:0]                  m_req_i;
    logic [NUM_MASTERS-1:0]                  m_gnt_o;
    logic [NUM_MASTERS-1:0]                  m_rvalid_o;
    logic [NUM_MASTERS-1:0]                  m_err_o;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0]       m_addr_i;
    logic [NUM_MASTERS-1:0]                  m_we_i;
    logic [NUM_MASTERS*BE_WIDTH-1:0]         m_be_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]       m_wdata_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]       m_rdata_o;

    logic [NUM_SLAVES-1:0]                   s_en_o;
    logic [NUM_SLAVES*SLAVE_ADDR_WIDTH-1:0]  s_addr_o;
    logic [NUM_SLAVES-1:0]                   s_we_o;
    logic [NUM_SLAVES*BE_WIDTH-1:0]          s_be_o;
    logic [NUM_SLAVES*DATA_WIDTH-1:0]        s_wdata_o;
    logic [NUM_SLAVES*DATA_WIDTH-1:0]        s_rdata_i;

    modport xbar (
        input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i, s_rdata_i,
        output m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o,
               s_en_o, s_addr_o, s_we_o, s_be_o, s_wdata_o
    );

    modport master (
        output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
        input  m_gnt_o, m_rvalid_o, m_err_o, m_rdata_o
    );

    modport slave (
        input  s_en_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
        output s_rdata_i
    );

endinterface

// File: rtl/mem_xbar_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with a registered priority pointer.
//   clk, rst - clock, asynchronous active-high reset (pointer -> 0)
//   req[N]   - requests
//   gnt[N]   - one-hot grant, combinational
// After a grant to w the pointer moves to (w+1) mod N; it holds when idle.
module rr_arbiter
    import mem_xbar_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_r;
    logic [PW-1:0] ptr_nxt_s;
    logic          found_s;

    // Grant the lowest requester at or above the pointer, else wrap to the lowest overall.
    always_comb begin
        gnt       = '0;
        ptr_nxt_s = ptr_r;
        found_s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found_s && req[i] && (PW'(i) >= ptr_r)) begin
                found_s   = 1'b1;
                gnt[i]    = 1'b1;
                ptr_nxt_s = (i == N - 1) ? '0 : PW'(i + 1);
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found_s && req[i]) begin
                found_s   = 1'b1;
                gnt[i]    = 1'b1;
                ptr_nxt_s = (i == N - 1) ? '0 : PW'(i + 1);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

endmodule

// File: rtl/mem_xbar.sv
// mem_xbar: NUM_MASTERS x NUM_SLAVES request/grant memory crossbar.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - mem_xbar_if.xbar: master handshake/payload/response and slave strobes
// Decode is table-driven (lowest matching slave wins); each slave has a
// round-robin arbiter; unmapped accesses are granted at once and answered
// with err=1 one cycle later. Grants are combinational, responses registered.
module mem_xbar
    import mem_xbar_pkg::*;
#(
    parameter int NUM_MASTERS      = 2,
    parameter int NUM_SLAVES       = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int SLAVE_ADDR_WIDTH = 13,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h2000_0000, 32'h0010_0000, 32'h1000_0000},
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hFFFF_F000, 32'hFFFF_8000, 32'hFFFF_8000}
) (
    input  logic   clk,
    input  logic   rst,
    mem_xbar_if.xbar bus
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    logic [MAX_SLAVES*ADDR_MAX-1:0] base_ext_s;
    logic [MAX_SLAVES*ADDR_MAX-1:0] mask_ext_s;
    dec_t                           dec_s  [NUM_MASTERS];
    logic [NUM_MASTERS-1:0]         sreq_s [NUM_SLAVES];
    logic [NUM_MASTERS-1:0]         sgnt_s [NUM_SLAVES];
    logic [NUM_MASTERS-1:0]         gnt_s;
    rsp_t                           rsp_r  [NUM_MASTERS];

    // Widen the parameter tables to the decoder's fixed layout.
    always_comb begin
        base_ext_s = '0;
        mask_ext_s = '0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            base_ext_s[j*ADDR_MAX +: ADDR_MAX] = ADDR_MAX'(SLAVE_BASE[j*ADDR_WIDTH +: ADDR_WIDTH]);
            mask_ext_s[j*ADDR_MAX +: ADDR_MAX] = ADDR_MAX'(SLAVE_MASK[j*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    end

    // Address decode per master.
    always_comb begin
        for (int k = 0; k < NUM_MASTERS; k++) begin
            dec_s[k] = decode(ADDR_MAX'(bus.m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]),
                              base_ext_s, mask_ext_s, NUM_SLAVES);
        end
    end

    // Per-slave request vectors; reset masks everything so no grant or strobe escapes.
    always_comb begin
        for (int j = 0; j < NUM_SLAVES; j++) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                sreq_s[j][k] = !rst && bus.m_req_i[k] && dec_s[k].hit &&
                               (dec_s[k].idx == idx_t'(j));
            end
        end
    end

    for (genvar j = 0; j < NUM_SLAVES; j++) begin : g_arb
        rr_arbiter #(.N(NUM_MASTERS)) u_arb (
            .clk (clk),
            .rst (rst),
            .req (sreq_s[j]),
            .gnt (sgnt_s[j])
        );
    end

    // Master grant: won a slave arbitration, or unmapped (granted immediately).
    always_comb begin
        for (int k = 0; k < NUM_MASTERS; k++) begin
            gnt_s[k] = !rst && bus.m_req_i[k] && !dec_s[k].hit;
            for (int j = 0; j < NUM_SLAVES; j++) begin
                gnt_s[k] = gnt_s[k] | sgnt_s[j][k];
            end
        end
        bus.m_gnt_o = gnt_s;
    end

    // Slave-side AND-OR mux; the arbiter grant is one-hot so at most one term survives.
    always_comb begin
        bus.s_en_o    = '0;
        bus.s_addr_o  = '0;
        bus.s_we_o    = '0;
        bus.s_be_o    = '0;
        bus.s_wdata_o = '0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            bus.s_en_o[j] = |sgnt_s[j];
            for (int k = 0; k < NUM_MASTERS; k++) begin
                bus.s_addr_o[j*SLAVE_ADDR_WIDTH +: SLAVE_ADDR_WIDTH] =
                    bus.s_addr_o[j*SLAVE_ADDR_WIDTH +: SLAVE_ADDR_WIDTH] |
                    ({SLAVE_ADDR_WIDTH{sgnt_s[j][k]}} &
                     bus.m_addr_i[k*ADDR_WIDTH + 2 +: SLAVE_ADDR_WIDTH]);
                bus.s_we_o[j] = bus.s_we_o[j] | (sgnt_s[j][k] & bus.m_we_i[k]);
                bus.s_be_o[j*BE_WIDTH +: BE_WIDTH] =
                    bus.s_be_o[j*BE_WIDTH +: BE_WIDTH] |
                    ({BE_WIDTH{sgnt_s[j][k]}} & bus.m_be_i[k*BE_WIDTH +: BE_WIDTH]);
                bus.s_wdata_o[j*DATA_WIDTH +: DATA_WIDTH] =
                    bus.s_wdata_o[j*DATA_WIDTH +: DATA_WIDTH] |
                    ({DATA_WIDTH{sgnt_s[j][k]}} & bus.m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

    // Response record per master: captured on every grant, retired one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                rsp_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
                rsp_r[k] <= '{valid: gnt_s[k], idx: dec_s[k].idx, err: !dec_s[k].hit};
            end
        end
    end

    // Response outputs: read data is steered from the recorded slave, zero on error/idle.
    always_comb begin
        bus.m_rvalid_o = '0;
        bus.m_err_o    = '0;
        bus.m_rdata_o  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            bus.m_rvalid_o[k] = rsp_r[k].valid;
            bus.m_err_o[k]    = rsp_r[k].valid & rsp_r[k].err;
            for (int j = 0; j < NUM_SLAVES; j++) begin
                bus.m_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] =
                    bus.m_rdata_o[k*DATA_WIDTH +: DATA_WIDTH] |
                    ({DATA_WIDTH{rsp_r[k].valid && !rsp_r[k].err &&
                                 (rsp_r[k].idx == idx_t'(j))}} &
                     bus.s_rdata_i[j*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    end

endmodule

// File: doc/mem_xbar.md
# mem_xbar

Parametrised request/grant crossbar that connects NUM_MASTERS core-style memory ports to NUM_SLAVES synchronous single-port slaves. It succeeds the fixed two-master, three-target interconnect in the SoC top level. It adds table-driven address decode, per-slave round-robin arbitration, back-to-back throughput and error responses for unmapped addresses. It sits between the zeroriscy instruction/LSU ports (and, later, a debug system-bus master) and the instruction RAM, data RAM and UART.

## Interface
- NUM_MASTERS, 2, number of master ports (≥1)
- NUM_SLAVES, 3, number of slave ports (≥1)
- ADDR_WIDTH, 32, master byte-address width
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8
- SLAVE_ADDR_WIDTH, 13, word-address width driven to slaves
- SLAVE_BASE, {32'h2000_0000, 32'h0010_0000, 32'h1000_0000}, packed NUM_SLAVES*ADDR_WIDTH base table; slave 0 occupies the LSBs
- SLAVE_MASK, {32'hFFFF_F000, 32'hFFFF_8000, 32'hFFFF_8000}, packed decode-mask table
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m_req_i  in  NUM_MASTERS  request
- m_gnt_o  out  NUM_MASTERS  grant, combinational
- m_rvalid_o  out  NUM_MASTERS  response valid, registered
- m_err_o  out  NUM_MASTERS  error flag, qualified by rvalid
- m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  byte address
- m_we_i  in  NUM_MASTERS  write enable
- m_be_i  in  NUM_MASTERS*DATA_WIDTH/8  byte enables
- m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  write data
- m_rdata_o  out  NUM_MASTERS*DATA_WIDTH  read data, qualified by rvalid
- s_en_o  out  NUM_SLAVES  slave access strobe
- s_addr_o  out  NUM_SLAVES*SLAVE_ADDR_WIDTH  word address: master addr[SLAVE_ADDR_WIDTH+1:2]
- s_we_o  out  NUM_SLAVES  write enable
- s_be_o  out  NUM_SLAVES*DATA_WIDTH/8  byte enables
- s_wdata_o  out  NUM_SLAVES*DATA_WIDTH  write data
- s_rdata_i  in  NUM_SLAVES*DATA_WIDTH  read data, valid one cycle after s_en_o

## Operation
- Decode: master k targets slave j when (addr & SLAVE_MASK[j]) == SLAVE_BASE[j]. If several slaves match, the lowest j wins. No match means an unmapped access.
- Arbitration: each slave has its own round-robin arbiter over the masters that target it. After a grant to master w, that slave's priority pointer becomes (w+1) mod NUM_MASTERS. The pointer does not move when the slave has no grant.
- A granted master's addr/we/be/wdata are muxed to the slave in the same cycle, and s_en_o[j] is 1. Ungranted slaves drive s_en_o=0, and their other outputs are don't-care.
- Unmapped access: m_gnt_o is 1 immediately with no slave strobe. The next cycle gives rvalid=1, err=1, rdata=0. This applies to reads and writes.
- Response: for every grant, the response register records {valid, slave index, err}. The next cycle gives rvalid=1, and rdata = s_rdata_i of the recorded slave (0 on err). Writes also return rvalid, and their rdata is don't-care.
- Different masters targeting different slaves are granted in the same cycle.
- Throughput: a master may hold req high continuously and be granted every cycle. There is never more than one outstanding response per master.

## Timing
- Request-to-grant latency is 0 cycles (combinational). Grant-to-rvalid latency is exactly 1 cycle.
- A master must hold addr, we, be and wdata stable while req=1 and gnt=0.
- Reset values: m_rvalid_o=0, m_err_o=0, m_rdata_o=0, all arbiter pointers=0.
- m_gnt_o and s_en_o are forced to 0 while rst=1.
- Reset asserted mid-transaction discards the pending response, so no rvalid follows.
- Contention: the loser sees gnt=0 and keeps req high. It is granted on the next free cycle per the pointer, so it waits at most NUM_MASTERS-1 grants.

## Structure
- mem_xbar_pkg holds:
  - the slave-index width localparam
  - the response-record struct {valid, idx, err}
  - the decode function (addr, base table, mask table) → {hit, idx}
- One sub-module, rr_arbiter, parametrised by N. Inputs: req[N]. Outputs: one-hot gnt[N]. It contains the registered pointer and is instantiated once per slave.

## Test plan
- Single read: M0 reads 0x1000_0010 → gnt same cycle, s_en_o[0]=1, s_addr_o[0]=13'h4; next cycle rvalid[0]=1, rdata = s_rdata_i[0].
- Parallel access: M0 reads 0x1000_0000 while M1 writes 0x0010_0004 with be=4'b0011 → both granted in one cycle, both rvalid next cycle.
- Contention: both masters hold req to 0x0010_0000 for 4 cycles from reset → grants alternate M0, M1, M0, M1.
- Unmapped access: M1 reads 0x3000_0000 → gnt=1 with all s_en_o=0; next cycle rvalid[1]=1, err[1]=1, rdata=0.
- Overlapping windows: with slave 0 and slave 2 both matching 0x2000_0000 → slave 0 is strobed.
- Reset mid-transaction: rst asserted in the grant cycle → no rvalid afterwards, pointers=0, and M1 wins no priority on the first post-reset contention.
